// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory slave: access size codes,
// the access FSM state type, the wait-state ceiling and the sub-word
// load extension helper.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b11;

    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Extend a right-aligned byte (val[7:0]) or half (val[15:0]) to 32 bits.
    function automatic logic [31:0] extend_load(input logic [15:0] val,
                                                input logic        is_half,
                                                input logic        uns);
        logic [31:0] res;
        if (is_half) begin
            res = uns ? {16'h0000, val} : {{16{val[15]}}, val};
        end else begin
            res = uns ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   size, offset    : access size code and byte offset within the word
//   st_data         : right-aligned store data
//   rd_word         : current contents of the addressed word
//   ld_unsigned     : zero-extend (1) or sign-extend (0) sub-word loads
//   lane_en         : per-byte write enables (all zero when misaligned)
//   wr_data         : store data replicated onto every lane
//   ld_data         : extracted and extended load result (0 when misaligned)
//   misaligned      : half on odd address or word on non-multiple-of-4
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    input  logic        ld_unsigned,
    output logic [3:0]  lane_en,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic        is_half;
    logic        is_word;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        // Size code 2'b10 is treated as a word, so only bit 1 matters here.
        is_half    = (size == SZ_HALF);
        is_word    = size[1];
        misaligned = (is_half && offset[0]) || (is_word && (offset != 2'b00));

        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (offset)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase

        // Replicating the store data means the lane enables alone pick the
        // destination bytes; no barrel shift is needed on the write path.
        lane_en = 4'b0000;
        wr_data = {4{st_data[7:0]}};
        ld_data = 32'h0000_0000;

        if (!misaligned) begin
            if (is_word) begin
                lane_en = 4'b1111;
                wr_data = st_data;
                ld_data = rd_word;
            end else if (is_half) begin
                lane_en = offset[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{st_data[15:0]}};
                ld_data = extend_load(half_sel, 1'b1, ld_unsigned);
            end else begin
                lane_en = 4'b0001 << offset;
                ld_data = extend_load({8'h00, byte_sel}, 1'b0, ld_unsigned);
            end
        end
    end

endmodule

// File: rtl/mips_data_mem.sv
// Parametrised data-memory slave for the MIPS single-cycle CPU.
//   clk, reset     : rising-edge clock, synchronous active-low reset
//   CPU_MIO        : access request (sampled only while idle)
//   mem_w          : 1 = store, 0 = load
//   Addr_in        : byte address; upper bits alias modulo the depth
//   Data_in        : right-aligned store data
//   StoreX         : access size (00 byte, 01 half, 1x word)
//   ld_unsigned    : zero-extend sub-word loads when set
//   Data_out       : load result, held until the next completion
//   MIO_ready      : one-cycle completion pulse
//   mem_err        : misalignment flag, valid with MIO_ready
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [1:0]  StoreX,
    input  logic        ld_unsigned,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        mem_err
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam int         CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    mem_state_t             state;
    mem_state_t             next_state;
    logic [CNT_W-1:0]       wait_cnt;

    // Latched request
    logic [ADDR_WIDTH+1:0]  addr_q;
    logic [31:0]            data_q;
    logic [1:0]             size_q;
    logic                   we_q;
    logic                   uns_q;

    // While idle the live bus feeds the datapath so that a zero-wait
    // access can complete on the same edge that samples the request.
    logic [ADDR_WIDTH+1:0]  sel_addr;
    logic [31:0]            sel_data;
    logic [1:0]             sel_size;
    logic                   sel_we;
    logic                   sel_uns;

    logic [31:0]            mem_array [DEPTH];
    logic [31:0]            rd_word;
    logic [3:0]             lane_en;
    logic [31:0]            wr_data;
    logic [31:0]            ld_data;
    logic                   misaligned;
    logic                   enter_done;

    logic                   unused_addr_hi;
    assign unused_addr_hi = ^Addr_in[31:ADDR_WIDTH+2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    next_state = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The counter value 1 is decremented to 0 on this edge.
                if (wait_cnt <= CNT_W'(1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        MIO_ready  = (state == ST_DONE);
        enter_done = (next_state == ST_DONE) && (state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE && CPU_MIO) begin
            wait_cnt <= WAIT_LD;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && CPU_MIO) begin
            addr_q <= Addr_in[ADDR_WIDTH+1:0];
            data_q <= Data_in;
            size_q <= StoreX;
            we_q   <= mem_w;
            uns_q  <= ld_unsigned;
        end
    end

    always_comb begin
        if (state == ST_IDLE) begin
            sel_addr = Addr_in[ADDR_WIDTH+1:0];
            sel_data = Data_in;
            sel_size = StoreX;
            sel_we   = mem_w;
            sel_uns  = ld_unsigned;
        end else begin
            sel_addr = addr_q;
            sel_data = data_q;
            sel_size = size_q;
            sel_we   = we_q;
            sel_uns  = uns_q;
        end
    end

    assign rd_word = mem_array[sel_addr[ADDR_WIDTH+1:2]];

    mem_lane_align u_align (
        .size        (sel_size),
        .offset      (sel_addr[1:0]),
        .st_data     (sel_data),
        .rd_word     (rd_word),
        .ld_unsigned (sel_uns),
        .lane_en     (lane_en),
        .wr_data     (wr_data),
        .ld_data     (ld_data),
        .misaligned  (misaligned)
    );

    // Result registers load on the edge entering DONE so they are valid
    // together with MIO_ready; stores and faulting accesses report zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Data_out <= 32'h0000_0000;
            mem_err  <= 1'b0;
        end else if (enter_done) begin
            mem_err  <= misaligned;
            Data_out <= (sel_we || misaligned) ? 32'h0000_0000 : ld_data;
        end
    end

    // Store commit on the edge leaving DONE; reset has priority and the
    // lane enables are already zero for a misaligned access.
    always_ff @(posedge clk) begin
        if (reset && state == ST_DONE && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_array[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
module tb_mips_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio [2];
    logic        mem_w   [2];
    logic [31:0] addr    [2];
    logic [31:0] din     [2];
    logic [1:0]  sx      [2];
    logic        uns     [2];
    logic [31:0] dout    [2];
    logic        ready   [2];
    logic        err     [2];

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference images of each instance.
    logic [7:0] mb0 [4096];
    logic [7:0] mb1 [64];

    always #5 clk = ~clk;

    mips_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .CPU_MIO(cpu_mio[0]), .mem_w(mem_w[0]),
        .Addr_in(addr[0]), .Data_in(din[0]), .StoreX(sx[0]),
        .ld_unsigned(uns[0]), .Data_out(dout[0]), .MIO_ready(ready[0]),
        .mem_err(err[0])
    );

    mips_data_mem #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .CPU_MIO(cpu_mio[1]), .mem_w(mem_w[1]),
        .Addr_in(addr[1]), .Data_in(din[1]), .StoreX(sx[1]),
        .ld_unsigned(uns[1]), .Data_out(dout[1]), .MIO_ready(ready[1]),
        .mem_err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain byte-array semantics of a little-endian memory.
    task automatic model(input int which, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s, input bit u,
                         output logic [31:0] ed, output bit ee);
        int n;
        int unsigned sz;
        int unsigned idx;
        logic [31:0] v;
        n  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        sz = (which == 0) ? 4096 : 64;
        ee = (a % n) != 0;
        ed = 32'h0;
        if (!ee) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) begin
                idx = (a + i) % sz;
                if (we) begin
                    if (which == 0) mb0[idx] = 8'(d >> (8 * i));
                    else            mb1[idx] = 8'(d >> (8 * i));
                end else begin
                    v = v | (32'((which == 0) ? mb0[idx] : mb1[idx]) << (8 * i));
                end
            end
            if (!we) begin
                if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                ed = v;
            end
        end
    endtask

    // One complete access: drive, wait for the pulse, compare with the model.
    task automatic access(input int which, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input bit u,
                          input string tag);
        logic [31:0] ed;
        logic [31:0] od;
        bit          ee;
        logic        oe;
        int          lat;
        bit          got;
        model(which, we, a, d, s, u, ed, ee);
        cpu_mio[which] = 1'b1;
        mem_w[which]   = we;
        addr[which]    = a;
        din[which]     = d;
        sx[which]      = s;
        uns[which]     = u;
        got = 0;
        lat = 0;
        od  = 32'hx;
        oe  = 1'bx;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) cpu_mio[which] = 1'b0;
            if (ready[which]) begin
                got = 1;
                lat = k;
                od  = dout[which];
                oe  = err[which];
            end
        end
        chk({tag, " latency"}, lat, (which == 0) ? 32'd3 : 32'd1);
        chk({tag, " mem_err"}, {31'b0, oe}, {31'b0, ee});
        if (!we || ee) chk({tag, " data"}, od, ed);
        @(posedge clk);
        #1;
        chk({tag, " pulse width"}, {31'b0, ready[which]}, 32'd0);
    endtask

    initial begin : main
        logic [31:0] ed;
        bit          ee;
        int          pulses;

        for (int i = 0; i < 2; i++) begin
            cpu_mio[i] = 1'b0; mem_w[i] = 1'b0; addr[i] = 32'h0;
            din[i] = 32'h0; sx[i] = 2'b11; uns[i] = 1'b0;
        end

        // Reset held for three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", {31'b0, ready[i]}, 32'd0);
            chk("reset data",  dout[i], 32'd0);
            chk("reset err",   {31'b0, err[i]}, 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Word traffic
        access(0, 1, 32'h10, 32'hDEADBEEF, 2'b11, 0, "word store 0x10");
        access(0, 0, 32'h10, 32'h0,        2'b11, 0, "word load 0x10");
        chk("deadbeef image", {mb0[19], mb0[18], mb0[17], mb0[16]}, 32'hDEADBEEF);

        // Byte merge and sub-word extension
        access(0, 1, 32'h11, 32'hAAAAAA7F, 2'b00, 0, "byte store 0x11");
        access(0, 0, 32'h10, 32'h0,        2'b11, 0, "merged word load");
        model(0, 0, 32'h13, 32'h0, 2'b00, 0, ed, ee);
        chk("model signed byte", ed, 32'hFFFFFFDE);
        access(0, 0, 32'h13, 32'h0,        2'b00, 0, "signed byte 0x13");
        access(0, 0, 32'h13, 32'h0,        2'b00, 1, "unsigned byte 0x13");
        access(0, 0, 32'h12, 32'h0,        2'b01, 0, "signed half 0x12");

        // Misaligned accesses
        access(0, 1, 32'h20, 32'hCAFEF00D, 2'b11, 0, "init 0x20");
        access(0, 1, 32'h21, 32'h00001234, 2'b01, 0, "misaligned half store");
        access(0, 0, 32'h20, 32'h0,        2'b11, 0, "0x20 unchanged");
        access(0, 0, 32'h22, 32'h0,        2'b11, 0, "misaligned word load");
        access(0, 0, 32'h22, 32'h0,        2'b10, 1, "half load 0x22 code10");

        // Request re-asserted during WAIT is ignored
        cpu_mio[0] = 1'b1; mem_w[0] = 1'b0; addr[0] = 32'h10; sx[0] = 2'b11;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) cpu_mio[0] = 1'b0;
            if (k == 2) cpu_mio[0] = 1'b1;
            if (k == 3) cpu_mio[0] = 1'b0;
            if (ready[0]) pulses++;
        end
        chk("busy single pulse", pulses, 32'd1);

        // Reset during WAIT aborts the store
        access(0, 1, 32'h30, 32'hA5A5A5A5, 2'b11, 0, "init 0x30");
        cpu_mio[0] = 1'b1; mem_w[0] = 1'b1; addr[0] = 32'h30;
        din[0] = 32'h12345678; sx[0] = 2'b11;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin cpu_mio[0] = 1'b0; reset = 1'b0; end
            if (k == 2) reset = 1'b1;
            if (ready[0]) pulses++;
        end
        chk("abort no pulse", pulses, 32'd0);
        access(0, 0, 32'h30, 32'h0, 2'b11, 0, "0x30 old value");

        // Zero wait states and address wrap on the 16-word instance
        access(1, 1, 32'h40, 32'h11223344, 2'b11, 0, "w0 store 0x40");
        access(1, 0, 32'h00, 32'h0,        2'b11, 0, "wrap load 0x00");
        chk("wrap image", {mb1[3], mb1[2], mb1[1], mb1[0]}, 32'h11223344);

        // Randomised traffic against the model
        for (int w = 0; w < 16; w++)
            access(0, 1, 32'h100 + 4 * w, $urandom(), 2'b11, 0, "rand init0");
        for (int t = 0; t < 40; t++)
            access(0, 32'($urandom_range(0, 1)) != 0, 32'h100 + $urandom_range(0, 63),
                   $urandom(), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 1)) != 0,
                   "rand dut0");
        for (int w = 0; w < 16; w++)
            access(1, 1, 32'(4 * w), $urandom(), 2'b11, 0, "rand init1");
        for (int t = 0; t < 40; t++)
            access(1, 32'($urandom_range(0, 1)) != 0, $urandom(),
                   $urandom(), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 1)) != 0,
                   "rand dut1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
